// File: rtl/packet_builder.sv
// Transmit framer: turns one packet descriptor into a 32-bit word stream
// (two header words, then payload) and keeps a sequence counter per stream.
module packet_builder #(
    parameter int NUM_STREAMS       = 8,
    parameter int MAX_PAYLOAD_BYTES = 32
) (
    input  logic                             clk,
    input  logic                             reset_b,
    input  logic [15:0]                      pkt_stream,
    input  logic [15:0]                      pkt_len,
    input  logic [0:MAX_PAYLOAD_BYTES*8-1]   pkt_payload,
    input  logic                             pkt_val,
    output logic                             pkt_ready,
    output logic                             pkt_err,
    output logic [31:0]                      dataOut,
    output logic                             dataOut_val,
    input  logic                             dataOut_ready,
    output logic                             dataOut_last,
    output logic [1:0]                       fsm_state
);

    localparam int          SIDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam logic [15:0] NS16   = 16'(NUM_STREAMS);
    localparam logic [15:0] MAXB16 = 16'(MAX_PAYLOAD_BYTES);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds data stable while valid && !ready.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR0    = 2'd1,
        HDR1    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t                            state;
    logic [SIDX_W-1:0]                 stream_idx;
    logic [15:0]                       len_r;
    logic [15:0]                       nwords_r;
    logic [15:0]                       widx;
    logic [0:MAX_PAYLOAD_BYTES*8-1]    payload_r;
    logic [31:0]                       seq_table [NUM_STREAMS];

    logic        desc_ok;
    logic [15:0] total;
    logic [31:0] seq_cur;
    logic [31:0] hdr0_word;
    logic [31:0] hdr1_word;

    assign fsm_state = state;
    assign desc_ok   = (pkt_stream < NS16) && (pkt_len <= MAXB16);
    assign total     = pkt_len + 16'd8;
    assign hdr0_word = {total[7:0], total[15:8], pkt_stream[7:0], pkt_stream[15:8]};
    assign seq_cur   = seq_table[stream_idx];
    assign hdr1_word = {seq_cur[7:0], seq_cur[15:8], seq_cur[23:16], seq_cur[31:24]};

    // Payload word w in wire-byte order; bytes past the packet length read as zero.
    function automatic logic [31:0] payload_word(
        input logic [0:MAX_PAYLOAD_BYTES*8-1] pl,
        input logic [15:0]                    len,
        input logic [15:0]                    w
    );
        logic [31:0] word;
        int          idx;
        word = '0;
        for (int b = 0; b < 4; b++) begin
            idx = 4 * int'(w) + b;
            if (idx < int'(len) && idx < MAX_PAYLOAD_BYTES) begin
                word[31-8*b -: 8] = pl[8*idx +: 8];
            end
        end
        return word;
    endfunction

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= IDLE;
            stream_idx   <= '0;
            len_r        <= '0;
            nwords_r     <= '0;
            widx         <= '0;
            payload_r    <= '0;
            pkt_ready    <= 1'b0;
            pkt_err      <= 1'b0;
            dataOut      <= '0;
            dataOut_val  <= 1'b0;
            dataOut_last <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                seq_table[i] <= 32'd1;
            end
        end else begin
            pkt_err <= 1'b0;
            case (state)
                IDLE: begin
                    pkt_ready <= 1'b1;
                    if (pkt_val && pkt_ready) begin
                        stream_idx <= pkt_stream[SIDX_W-1:0];
                        len_r      <= pkt_len;
                        nwords_r   <= (pkt_len + 16'd3) >> 2;
                        payload_r  <= pkt_payload;
                        if (!desc_ok) begin
                            pkt_err <= 1'b1;
                        end else begin
                            state        <= HDR0;
                            pkt_ready    <= 1'b0;
                            dataOut      <= hdr0_word;
                            dataOut_val  <= 1'b1;
                            dataOut_last <= 1'b0;
                        end
                    end
                end

                HDR0: begin
                    if (dataOut_ready) begin
                        state        <= HDR1;
                        dataOut      <= hdr1_word;
                        dataOut_last <= (len_r == 16'd0);
                    end
                end

                HDR1: begin
                    if (dataOut_ready) begin
                        if (dataOut_last) begin
                            // Empty payload: the packet completes on its second header word.
                            seq_table[stream_idx] <= seq_cur + 32'd1;
                            state        <= IDLE;
                            pkt_ready    <= 1'b1;
                            dataOut      <= '0;
                            dataOut_val  <= 1'b0;
                            dataOut_last <= 1'b0;
                        end else begin
                            state        <= PAYLOAD;
                            widx         <= '0;
                            dataOut      <= payload_word(payload_r, len_r, 16'd0);
                            dataOut_last <= (nwords_r == 16'd1);
                        end
                    end
                end

                PAYLOAD: begin
                    if (dataOut_ready) begin
                        if (dataOut_last) begin
                            seq_table[stream_idx] <= seq_cur + 32'd1;
                            state        <= IDLE;
                            pkt_ready    <= 1'b1;
                            dataOut      <= '0;
                            dataOut_val  <= 1'b0;
                            dataOut_last <= 1'b0;
                        end else begin
                            widx         <= widx + 16'd1;
                            dataOut      <= payload_word(payload_r, len_r, widx + 16'd1);
                            dataOut_last <= ((widx + 16'd2) == nwords_r);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
